// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Purpose  : Shares one registered 8-bit signed adder between two requesters.
//            Round-robin arbitration picks a winner in IDLE. The operands are
//            captured (EXEC), the sum and the signed-overflow flag are
//            registered (RESP), and the result is held until the consumer
//            takes it. Only one operation is in flight at a time.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_reqN_valid      - requester N has an operand pair (N = 0, 1)
//            i_reqN_a/_b [7:0] - requester N signed operands
//            o_reqN_ready      - requester N operands accepted this cycle
//            o_res_valid       - result available
//            o_res_data  [7:0] - signed sum, wrapped to 8 bits
//            o_res_id          - requester that owns o_res_data
//            o_res_ovf         - signed overflow of o_res_data
//            i_res_ready       - consumer takes the result this cycle
//            o_op_count  [7:0] - completed-operation counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module adder_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_a,
  input  logic [7:0] i_req0_b,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_a,
  input  logic [7:0] i_req1_b,
  output logic       o_req1_ready,
  output logic       o_res_valid,
  output logic [7:0] o_res_data,
  output logic       o_res_id,
  output logic       o_res_ovf,
  input  logic       i_res_ready,
  output logic [7:0] o_op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_ptr;       // requester favoured when both are valid
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic       r_op_id;
  logic       r_res_valid;
  logic [7:0] r_res_data;
  logic       r_res_id;
  logic       r_res_ovf;
  logic [7:0] r_op_count;

  logic       w_grant0;
  logic       w_grant1;
  logic [7:0] w_sum;
  logic       w_ovf;

  // A grant already includes VALID, so a grant is the handshake itself.
  // Masking with rst keeps both READYs low while reset is held, so a
  // requester never sees a handshake that reset is about to discard.
  assign w_grant0 = (r_state == S_IDLE) && !rst && i_req0_valid
                    && (!i_req1_valid || !r_ptr);
  assign w_grant1 = (r_state == S_IDLE) && !rst && i_req1_valid
                    && (!i_req0_valid || r_ptr);

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;

  assign w_sum = r_op_a + r_op_b;
  // Overflow: both operands have the same sign and the sum has the other sign.
  assign w_ovf = (r_op_a[7] == r_op_b[7]) && (w_sum[7] != r_op_a[7]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_op_a      <= 8'h00;
      r_op_b      <= 8'h00;
      r_op_id     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
      r_res_id    <= 1'b0;
      r_res_ovf   <= 1'b0;
      r_op_count  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_op_a  <= w_grant1 ? i_req1_a : i_req0_a;
            r_op_b  <= w_grant1 ? i_req1_b : i_req0_b;
            r_op_id <= w_grant1;
            // Point at the requester that was not granted.
            r_ptr   <= w_grant0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= w_sum;
          r_res_ovf   <= w_ovf;
          r_res_id    <= r_op_id;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_id    = r_res_id;
  assign o_res_ovf   = r_res_ovf;
  assign o_op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Purpose  : Self-checking bench for adder_arbiter. A transaction-level
//            reference model (round-robin pointer, one pending result with
//            its age, a completion count) predicts READY, the result and
//            OP_COUNT every cycle, under directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

  logic       clk;
  logic       rst;
  logic       i_req0_valid;
  logic [7:0] i_req0_a;
  logic [7:0] i_req0_b;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [7:0] i_req1_a;
  logic [7:0] i_req1_b;
  logic       o_req1_ready;
  logic       o_res_valid;
  logic [7:0] o_res_data;
  logic       o_res_id;
  logic       o_res_ovf;
  logic       i_res_ready;
  logic [7:0] o_op_count;

  adder_arbiter u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .o_req1_ready (o_req1_ready),
    .o_res_valid  (o_res_valid),
    .o_res_data   (o_res_data),
    .o_res_id     (o_res_id),
    .o_res_ovf    (o_res_ovf),
    .i_res_ready  (i_res_ready),
    .o_op_count   (o_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic       m_ptr;
  logic       m_pend;      // an accepted operation not yet consumed
  int         m_age;       // cycles since the accept cycle
  logic [7:0] m_data;
  logic       m_id;
  logic       m_ovf;
  int         m_count;
  logic       m_zero;      // result registers still hold reset values

  // Per-cycle observations for directed tests
  logic       hs;
  logic       hs_id;
  logic       got_res;
  logic [7:0] obs_data;
  logic       obs_ovf;
  logic       obs_id;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle, compare outputs with the model, then advance the model
  // across the coming rising edge.
  task automatic cycle(input logic r, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic rr);
    logic e_r0, e_r1, e_valid;
    int   s;
    @(negedge clk);
    rst = r;
    i_req0_valid = v0; i_req0_a = a0; i_req0_b = b0;
    i_req1_valid = v1; i_req1_a = a1; i_req1_b = b1;
    i_res_ready = rr;
    #1;
    e_r0    = !r && !m_pend && v0 && (!v1 || m_ptr == 1'b0);
    e_r1    = !r && !m_pend && v1 && (!v0 || m_ptr == 1'b1);
    e_valid = m_pend && (m_age >= 2);
    check("req0_ready", {15'b0, o_req0_ready}, {15'b0, e_r0});
    check("req1_ready", {15'b0, o_req1_ready}, {15'b0, e_r1});
    check("res_valid", {15'b0, o_res_valid}, {15'b0, e_valid});
    check("op_count", {8'b0, o_op_count}, {8'b0, 8'(m_count)});
    if (e_valid) begin
      check("res_data", {8'b0, o_res_data}, {8'b0, m_data});
      check("res_id", {15'b0, o_res_id}, {15'b0, m_id});
      check("res_ovf", {15'b0, o_res_ovf}, {15'b0, m_ovf});
    end else if (m_zero) begin
      check("res_rstval", {6'b0, o_res_id, o_res_ovf, o_res_data}, 16'h0);
    end
    hs      = e_r0 || e_r1;
    hs_id   = e_r1;
    got_res = e_valid && rr && !r;
    if (e_valid) begin
      obs_data = o_res_data; obs_ovf = o_res_ovf; obs_id = o_res_id;
    end
    // Model update
    if (r) begin
      m_pend = 1'b0; m_ptr = 1'b0; m_count = 0; m_zero = 1'b1;
    end else if (m_pend) begin
      if (m_age >= 2) begin
        if (rr) begin
          m_pend  = 1'b0;
          m_count = (m_count + 1) % 256;
        end
      end else begin
        m_age++;
        if (m_age == 2) m_zero = 1'b0;
      end
    end else if (hs) begin
      m_id   = hs_id;
      m_data = hs_id ? 8'(a1 + b1) : 8'(a0 + b0);
      s      = hs_id ? (int'($signed(a1)) + int'($signed(b1)))
                     : (int'($signed(a0)) + int'($signed(b0)));
      m_ovf  = (s > 127) || (s < -128);
      m_pend = 1'b1;
      m_age  = 1;
      m_ptr  = !hs_id;
    end
  endtask

  task automatic idle_cycle(input logic rr);
    cycle(1'b0, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom), rr);
  endtask

  // One complete operation from requester id; returns the observed result.
  task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic ov);
    int n;
    n = 0;
    do begin
      cycle(1'b0, !id, a, b, id, a, b, 1'b1);
      n++;
    end while (!hs && n < 10);
    if (!hs) check("op_accept_timeout", 16'h0, 16'h1);
    n = 0;
    do begin
      idle_cycle(1'b1);
      n++;
    end while (!got_res && n < 10);
    if (!got_res) check("op_result_timeout", 16'h0, 16'h1);
    d  = obs_data;
    ov = obs_ovf;
  endtask

  initial begin
    logic [7:0] d;
    logic       ov;
    logic       grants[$];

    m_ptr = 1'b0; m_pend = 1'b0; m_age = 0; m_count = 0; m_zero = 1'b1;
    m_data = 8'h00; m_id = 1'b0; m_ovf = 1'b0;
    obs_data = 8'h00; obs_ovf = 1'b0; obs_id = 1'b0;
    rst = 1'b1; i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_a = 8'h00; i_req0_b = 8'h00; i_req1_a = 8'h00; i_req1_b = 8'h00;
    i_res_ready = 1'b0;

    // Reset, with both requesters valid to show READY stays low
    cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1);
    cycle(1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1);
    idle_cycle(1'b1);

    // Single operation: 5 + 3
    do_op(1'b0, 8'h05, 8'h03, d, ov);
    check("single_data", {7'b0, ov, d}, 16'h0008);
    check("single_id", {15'b0, obs_id}, 16'h0);
    idle_cycle(1'b0);
    check("single_count", {8'b0, o_op_count}, 16'h0001);

    // Overflow corner cases
    do_op(1'b1, 8'h7F, 8'h01, d, ov);
    check("ovf_pos", {7'b0, ov, d}, 16'h0180);
    do_op(1'b0, 8'h80, 8'hFF, d, ov);
    check("ovf_neg", {7'b0, ov, d}, 16'h017F);
    do_op(1'b1, 8'hFF, 8'h01, d, ov);
    check("no_ovf_wrap", {7'b0, ov, d}, 16'h0000);

    // Contention from reset: grants alternate starting with requester 0
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b1);
      if (hs) grants.push_back(hs_id);
    end
    check("cont_ngrants", 16'(grants.size()), 16'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check("cont_order", {15'b0, grants[i]}, {15'b0, 1'(i % 2)});

    // Backpressure: result held for 5 cycles, no READY meanwhile
    idle_cycle(1'b1);
    cycle(1'b0, 1'b1, 8'h10, 8'h20, 1'b0, 8'h00, 8'h00, 1'b0);
    check("bp_accept", {15'b0, hs}, 16'h1);
    cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0);
    check("bp_held", {7'b0, o_res_valid, o_res_data}, 16'h0130);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle_cycle(1'b1);
    check("bp_release", {15'b0, o_res_valid}, 16'h0);

    // Reset during EXEC discards the operation
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    idle_cycle(1'b1);
    check("rmo_outputs", {6'b0, o_res_valid, o_res_ovf, o_res_data}, 16'h0);
    check("rmo_count", {8'b0, o_op_count}, 16'h0);
    cycle(1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 8'h02, 8'h02, 1'b1);
    check("rmo_ptr0", {14'b0, hs, hs_id}, 16'h2);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Counter wrap after 256 completed operations
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 256; i++)
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), d, ov);
    idle_cycle(1'b1);
    check("count_wrap", {8'b0, o_op_count}, 16'h0);

    // Random traffic with occasional reset and backpressure
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
